// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2
  } t_seq_det_state;

  // Widest mask len_mask can build; callers size-cast down to their MAX_LEN.
  localparam int LEN_MASK_W = 32;

  function automatic logic [LEN_MASK_W-1:0] len_mask(input int len);
    logic [LEN_MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < LEN_MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Purpose: W-bit up counter with synchronous clear that sticks at all-ones.
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; clr beats inc in the same cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Purpose: runtime-programmable serial bit-pattern detector with saturating match count.
// Latency: match pulses one cycle after the completing bit is sampled.
// Backpressure: none; in_valid gaps hold state, cfg_load drops a coincident bit.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_t;

  cfg_t               cfg_q;
  logic               cfg_err_q;
  t_seq_det_state     state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  logic               match_q, match_d;
  logic               len_illegal, accept, reaches_len, cmp_eq, hit;

  assign len_illegal = (cfg_len == '0) || (cfg_len > LEN_MAX);
  assign mask        = MAX_LEN'(len_mask(int'(cfg_q.len)));
  assign hist_shift  = {hist_q[MAX_LEN-2:0], in_bit};
  assign fill_inc    = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
  assign reaches_len = (fill_inc >= cfg_q.len);
  assign cmp_eq      = ((hist_shift ^ cfg_q.pattern) & mask) == '0;

  // A bit arriving with a config load or while disabled is discarded.
  assign accept = (state_q != ST_IDLE) && enable && in_valid && !cfg_load;
  assign hit    = accept && cmp_eq && ((state_q == ST_SEARCH) || reaches_len);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (cfg_load) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = (enable && !len_illegal) ? ST_FILL : ST_IDLE;
    end else if (!enable) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          hist_d = '0;
          fill_d = '0;
          if (!cfg_err_q) state_d = ST_FILL;
        end
        ST_FILL: begin
          if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (reaches_len) state_d = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (hit) begin
        match_d = 1'b1;
        // Non-overlap: the matched bits may not be reused by the next match.
        if (!cfg_q.overlap) begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cfg_q     <= '{pattern: '0, len: LEN_MAX, overlap: 1'b1};
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      if (cfg_load) begin
        cfg_q     <= '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
        cfg_err_q <= len_illegal;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (match_q),
    .cnt (match_cnt)
  );

  assign match   = match_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed and random stimulus for seq_det_prog, checked every cycle against a queue-based model.
module tb_seq_det_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, enable, cfg_load, cfg_overlap, cnt_clr, in_valid, in_bit;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               match, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int checks = 0;
  int errors = 0;
  int seen   = 0;

  // Reference model: accepted bits since the last clear, oldest first.
  bit                 q[$];
  bit                 m_match, m_err, m_run, m_ov;
  int                 m_cnt, m_len;
  logic [MAX_LEN-1:0] m_pat;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  // Last m_len received bits equal the pattern read first-bit-at-MSB.
  function automatic bit tail_matches();
    if (m_len < 1 || q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc, nm;
    int nc;
    if (rst) begin
      m_match = 1'b0; m_cnt = 0; m_err = 1'b0; m_run = 1'b0;
      m_pat = '0; m_len = MAX_LEN; m_ov = 1'b1;
      q.delete();
    end else begin
      nc  = cnt_clr ? 0 : ((m_match && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
      acc = m_run && enable && in_valid && !cfg_load;
      nm  = 1'b0;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ov  = cfg_overlap;
        m_err = (m_len == 0) || (m_len > MAX_LEN);
        q.delete();
      end else if (!enable) begin
        q.delete();
      end else if (acc) begin
        q.push_back(in_bit);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        if (tail_matches()) begin
          nm = 1'b1;
          if (!m_ov) q.delete();
        end
      end
      m_run   = enable && !m_err;
      m_match = nm;
      m_cnt   = nc;
    end
    @(posedge clk);
    #1;
    check("match", 32'(match), 32'(m_match));
    check("match_cnt", 32'(match_cnt), 32'(m_cnt));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    if (match) seen++;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input bit b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Bits go out MSB first.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ov);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    tick();
    cfg_load    = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cfg_pattern = '0; cfg_len = '0;
    gap(2);
    rst = 1'b0; enable = 1'b1;
    gap(1);

    // Overlapping 1101 inside 11011011
    load(16'hD, 4, 1'b1);
    seen = 0;
    send_bits(32'b11011011, 8);
    gap(2);
    check("t1_pulses", 32'(seen), 32'd2);
    check("t1_cnt", 32'(match_cnt), 32'd2);

    // Same stream, non-overlapping
    clear_cnt();
    load(16'hD, 4, 1'b0);
    seen = 0;
    send_bits(32'b11011011, 8);
    gap(2);
    check("t2_pulses", 32'(seen), 32'd1);
    check("t2_cnt", 32'(match_cnt), 32'd1);

    // Near misses with valid gaps, then a completing tail
    clear_cnt();
    load(16'hD, 4, 1'b1);
    seen = 0;
    send_bits(32'b1010, 4);
    gap(3);
    send_bits(32'b1011, 4);
    check("t3_no_pulse", 32'(seen), 32'd0);
    send_bits(32'b011, 3);
    gap(2);
    check("t3_pulses", 32'(seen), 32'd1);

    // len=1 saturation and clear-over-increment
    clear_cnt();
    load(16'h1, 1, 1'b1);
    seen = 0;
    repeat (5) send(1'b1);
    gap(2);
    check("t4_pulses", 32'(seen), 32'd5);
    check("t4_sat", 32'(match_cnt), 32'(CNT_MAX));
    send(1'b0);
    send(1'b1);
    check("t4_match_hi", 32'(match), 32'd1);
    clear_cnt();
    gap(1);
    check("t4_clr_wins", 32'(match_cnt), 32'd0);
    load(16'h1, 1, 1'b0);
    seen = 0;
    repeat (3) send(1'b1);
    gap(1);
    check("t4_nonovl_pulses", 32'(seen), 32'd3);

    // cfg_load with a coincident valid bit drops the bit
    clear_cnt();
    load(16'hD, 4, 1'b1);
    seen = 0;
    send_bits(32'b110, 3);
    cfg_load = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    gap(1);
    check("t5_dropped", 32'(seen), 32'd0);
    send_bits(32'b1101, 4);
    gap(1);
    check("t5_pulses", 32'(seen), 32'd1);

    // Illegal lengths
    clear_cnt();
    load(16'h1, 1, 1'b1);
    send(1'b1);
    gap(2);
    load(16'hFFFF, 0, 1'b1);
    check("t6_err_len0", 32'(cfg_err), 32'd1);
    seen = 0;
    repeat (8) send(1'b1);
    gap(1);
    check("t6_no_pulse", 32'(seen), 32'd0);
    check("t6_cnt_held", 32'(match_cnt), 32'd1);
    load(16'hF, 17, 1'b1);
    check("t6_err_len17", 32'(cfg_err), 32'd1);
    load(16'hF, 4, 1'b1);
    check("t6_err_clear", 32'(cfg_err), 32'd0);
    seen = 0;
    send_bits(32'b1111, 4);
    gap(1);
    check("t6_recover", 32'(seen), 32'd1);

    // Reset mid-pattern: 16 zeros spanning the reset must not match
    load(16'h0, 16, 1'b1);
    send_bits(32'h0, 10);
    rst = 1'b1;
    tick();
    check("t7_rst_cnt", 32'(match_cnt), 32'd0);
    check("t7_rst_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    gap(1);
    seen = 0;
    send_bits(32'h0, 15);
    check("t7_no_span", 32'(seen), 32'd0);
    send(1'b0);
    gap(1);
    check("t7_len16", 32'(seen), 32'd1);

    // Randomized traffic against the model
    for (int r = 0; r < 10; r++) begin
      rst    = 1'b0;
      enable = 1'b1;
      load(MAX_LEN'($urandom), (r == 9) ? MAX_LEN : int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 250; c++) begin
        enable   = ($urandom_range(0, 39) != 0);
        in_valid = enable && ($urandom_range(0, 3) != 0);
        in_bit   = 1'($urandom_range(0, 1));
        cnt_clr  = ($urandom_range(0, 19) == 0);
        rst      = ($urandom_range(0, 299) == 0);
        tick();
      end
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
    end
    rst = 1'b0;
    gap(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
